// File: rtl/updown_counter_load.sv
// updown_counter_load: loadable up/down modulo counter with wrap/saturate, terminal-count and compare flags.
// Optional en-cycle prescaler enabled by defining UDCNT_PRESCALE_EN. Rev 1.0
`default_nettype none

module updown_counter_load #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             cmp_match
);

  if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
    $error("updown_counter_load: WIDTH and PRESCALE must both be >= 2");
  end

  logic             step;
  logic [WIDTH-1:0] next_out;
  logic             next_tc;
  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   max_ext;
  logic [WIDTH:0]   data_ext;

  // Bounds are compared one bit wider so a MAX_VAL below the full range never aliases.
  assign cur_ext  = {1'b0, out};
  assign max_ext  = {1'b0, MAX_VAL};
  assign data_ext = {1'b0, data};

`ifdef UDCNT_PRESCALE_EN
  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0] ps_cnt;
  logic            ps_tick;

  assign ps_tick = (ps_cnt == PS_W'(PRESCALE - 1));
  assign step    = en & ~load & ps_tick;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= ps_tick ? '0 : ps_cnt + PS_W'(1);
    end
  end
`else
  assign step = en & ~load;
`endif

  always_comb begin
    next_out = out;
    next_tc  = 1'b0;
    if (load) begin
      next_out = (data_ext > max_ext) ? MAX_VAL : data;
    end else if (step) begin
      if (up) begin
        if (cur_ext < max_ext) begin
          next_out = out + WIDTH'(1);
        end else begin
          next_tc  = 1'b1;
          next_out = sat_mode ? MAX_VAL : '0;
        end
      end else begin
        if (cur_ext != '0) begin
          next_out = out - WIDTH'(1);
        end else begin
          next_tc  = 1'b1;
          next_out = sat_mode ? '0 : MAX_VAL;
        end
      end
    end
  end

  // The compare looks at the value being registered, so the flag lines up with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      tc        <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      out       <= next_out;
      tc        <= next_tc;
      cmp_match <= (next_out == cmp_val);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_load.sv
// Scoreboard bench for updown_counter_load: two instances (MAX_VAL=9 and MAX_VAL=255), directed vectors.
`default_nettype none

module tb_updown_counter_load;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       up = 1'b1;
  logic       sat_mode = 1'b0;
  logic [7:0] data = 8'd0;
  logic [7:0] cmp_val = 8'd0;

  logic [7:0] out_a, out_b;
  logic       tc_a, tc_b, match_a, match_b;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    bit         sel;
    logic [7:0] out;
    logic       tc;
    logic       match;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  updown_counter_load #(.WIDTH(8), .MAX_VAL(8'd9), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up),
    .sat_mode(sat_mode), .cmp_val(cmp_val), .out(out_a), .tc(tc_a), .cmp_match(match_a)
  );

  updown_counter_load #(.WIDTH(8), .MAX_VAL(8'd255), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up),
    .sat_mode(sat_mode), .cmp_val(cmp_val), .out(out_b), .tc(tc_b), .cmp_match(match_b)
  );

  task automatic chk(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  // Monitor: every edge that follows a driven vector yields one registered response.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel) begin
        chk(e.name, "out", out_b, e.out);
        chk(e.name, "tc", {7'd0, tc_b}, {7'd0, e.tc});
        chk(e.name, "cmp_match", {7'd0, match_b}, {7'd0, e.match});
      end else begin
        chk(e.name, "out", out_a, e.out);
        chk(e.name, "tc", {7'd0, tc_a}, {7'd0, e.tc});
        chk(e.name, "cmp_match", {7'd0, match_a}, {7'd0, e.match});
      end
    end
  end

  task automatic vec(input string name, input bit sel,
                     input logic r, input logic l, input logic e, input logic u, input logic s,
                     input logic [7:0] d, input logic [7:0] c,
                     input logic [7:0] eo, input logic et, input logic em);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; sat_mode = s; data = d; cmp_val = c;
    x.name = name; x.sel = sel; x.out = eo; x.tc = et; x.match = em;
    sb.push_back(x);
  endtask

  initial begin
`ifndef UDCNT_PRESCALE_EN
    // Reset and load clamp on MAX_VAL=9; cmp_val 200 is above MAX_VAL and must never match.
    //   name            sel r  l  e  u  s  data  cmp   out tc m
    vec("rst0",          0, 1, 0, 0, 1, 0, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("rst1",          0, 1, 0, 0, 1, 0, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("load_clamp",    0, 0, 1, 0, 1, 0, 8'd200, 8'd200, 8'd9, 0, 0);
    // Up wrap from 7.
    vec("load7",         0, 0, 1, 0, 1, 0, 8'd7,   8'd200, 8'd7, 0, 0);
    vec("up_8",          0, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd8, 0, 0);
    vec("up_9",          0, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd9, 0, 0);
    vec("up_wrap0",      0, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd0, 1, 0);
    vec("up_1",          0, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd1, 0, 0);
    // Down saturate from 2, then release en, then down wrap from 0.
    vec("load2",         0, 0, 1, 0, 0, 0, 8'd2,   8'd200, 8'd2, 0, 0);
    vec("dn_1",          0, 0, 0, 1, 0, 1, 8'd0,   8'd200, 8'd1, 0, 0);
    vec("dn_0",          0, 0, 0, 1, 0, 1, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("dn_sat_a",      0, 0, 0, 1, 0, 1, 8'd0,   8'd200, 8'd0, 1, 0);
    vec("dn_sat_b",      0, 0, 0, 1, 0, 1, 8'd0,   8'd200, 8'd0, 1, 0);
    vec("dn_hold",       0, 0, 0, 0, 0, 1, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("dn_wrap9",      0, 0, 0, 1, 0, 0, 8'd0,   8'd200, 8'd9, 1, 0);
    vec("up_sat9",       0, 0, 0, 1, 1, 1, 8'd0,   8'd200, 8'd9, 1, 0);
    // Priority and direction flips.
    vec("prio_rst",      0, 1, 1, 1, 1, 0, 8'd5,   8'd200, 8'd0, 0, 0);
    vec("prio_load",     0, 0, 1, 1, 1, 0, 8'd5,   8'd200, 8'd5, 0, 0);
    vec("flip_up6",      0, 0, 0, 1, 1, 0, 8'd5,   8'd200, 8'd6, 0, 0);
    vec("flip_dn5",      0, 0, 0, 1, 0, 0, 8'd5,   8'd200, 8'd5, 0, 0);
    vec("flip_up6b",     0, 0, 0, 1, 1, 0, 8'd5,   8'd200, 8'd6, 0, 0);
    // Compare on MAX_VAL=255.
    vec("cmp_rst",       1, 1, 0, 0, 1, 0, 8'd0,   8'd3,   8'd0, 0, 0);
    vec("cmp_1",         1, 0, 0, 1, 1, 0, 8'd0,   8'd3,   8'd1, 0, 0);
    vec("cmp_2",         1, 0, 0, 1, 1, 0, 8'd0,   8'd3,   8'd2, 0, 0);
    vec("cmp_3",         1, 0, 0, 1, 1, 0, 8'd0,   8'd3,   8'd3, 0, 1);
    vec("cmp_hold_a",    1, 0, 0, 0, 1, 0, 8'd0,   8'd3,   8'd3, 0, 1);
    vec("cmp_hold_b",    1, 0, 0, 0, 1, 0, 8'd0,   8'd3,   8'd3, 0, 1);
    vec("cmp_chg4",      1, 0, 0, 0, 1, 0, 8'd0,   8'd4,   8'd3, 0, 0);
    vec("cmp_4",         1, 0, 0, 1, 1, 0, 8'd0,   8'd4,   8'd4, 0, 1);
    vec("load255",       1, 0, 1, 1, 1, 0, 8'd255, 8'd4,   8'd255, 0, 0);
    vec("wrap255",       1, 0, 0, 1, 1, 0, 8'd0,   8'd0,   8'd0, 1, 1);
    vec("load_match",    1, 0, 1, 0, 1, 0, 8'd77,  8'd77,  8'd77, 0, 1);
`else
    // Prescaled stepping on MAX_VAL=255 with PRESCALE=4.
    vec("ps_rst",        1, 1, 0, 0, 1, 0, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("ps_e1",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("ps_e2",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("ps_e3",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd0, 0, 0);
    vec("ps_e4",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd1, 0, 0);
    vec("ps_e5",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd1, 0, 0);
    vec("ps_e6",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd1, 0, 0);
    vec("ps_e7",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd1, 0, 0);
    vec("ps_e8",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_e1",        1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_e2",        1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_off1",      1, 0, 0, 0, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_off2",      1, 0, 0, 0, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_off3",      1, 0, 0, 0, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_e3",        1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd2, 0, 0);
    vec("gap_e4",        1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd3, 0, 0);
    vec("ld_e1",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd3, 0, 0);
    vec("ld_e2",         1, 0, 0, 1, 1, 0, 8'd0,   8'd200, 8'd3, 0, 0);
    vec("ld_mid",        1, 0, 1, 1, 1, 0, 8'd10,  8'd11,  8'd10, 0, 0);
    vec("ld_e1b",        1, 0, 0, 1, 1, 0, 8'd0,   8'd11,  8'd10, 0, 0);
    vec("ld_e2b",        1, 0, 0, 1, 1, 0, 8'd0,   8'd11,  8'd10, 0, 0);
    vec("ld_e3b",        1, 0, 0, 1, 1, 0, 8'd0,   8'd11,  8'd10, 0, 0);
    vec("ld_e4b",        1, 0, 0, 1, 1, 0, 8'd0,   8'd11,  8'd11, 0, 1);
`endif
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter_load.md
Name: updown_counter_load

Overview:
Parametrised successor to the team's 8-bit loadable up-counter. Adds configurable width and modulo top value, up/down direction, wrap or saturate mode, a terminal-count pulse, and a compare-match flag. Used as the general event/timer counter in control and datapath blocks.

Parameters:
WIDTH, 8, counter and data width in bits (>= 2).
MAX_VAL, 2**WIDTH-1, top count value; legal count range is 0..MAX_VAL.
PRESCALE, 4, en-cycles per count step; used only when UDCNT_PRESCALE_EN is defined (>= 2).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable, sampled each edge.
load  input  1  synchronous parallel load.
data  input  WIDTH  load value.
up  input  1  direction: 1 = increment, 0 = decrement.
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
cmp_val  input  WIDTH  compare value.
out  output  WIDTH  registered count.
tc  output  1  registered terminal-count pulse.
cmp_match  output  1  registered compare flag.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. On rst: out=0, tc=0, cmp_match=0, prescale state cleared.
- Priority each edge: rst > load > step > hold.
- Load: out <= min(data, MAX_VAL); tc <= 0. Load overrides en, up and sat_mode.
- Step condition: en=1 and no load (with the optional feature, additionally the prescale tick). No step means out holds and tc <= 0.
- Up step: if out < MAX_VAL, out <= out+1 and tc <= 0. If out == MAX_VAL: in wrap mode out <= 0; in saturate mode out holds at MAX_VAL. In both modes tc <= 1.
- Down step: if out > 0, out <= out-1 and tc <= 0. If out == 0: in wrap mode out <= MAX_VAL; in saturate mode out holds at 0. In both modes tc <= 1.
- tc timing: high for exactly one cycle, in the cycle after each boundary-crossing step.
  - Repeated steps while saturated produce tc=1 on every such step, so tc stays high while en=1.
- Direction and mode changes: up and sat_mode are sampled per edge. Reversing direction mid-count takes effect on the next step with no extra latency.
- Arithmetic: computed at WIDTH+1 bits internally; no overflow aliasing when MAX_VAL < 2**WIDTH-1. out never exceeds MAX_VAL.
- cmp_match: each non-reset edge, cmp_match <= (next value of out == cmp_val).
  - Result: cmp_match is 1 exactly in the cycles where out equals the cmp_val sampled at the preceding edge.
  - This holds for load, step and hold; a match while holding stays asserted.
- cmp_val > MAX_VAL can never match.
- Latency: load, step and flags all take 1 cycle; no combinational path from any input to any output.

Optional Feature:
Macro UDCNT_PRESCALE_EN.
- Defined: an internal counter (width clog2(PRESCALE)) advances on each cycle with en=1 and no load. It emits a tick on the PRESCALE-th such cycle, then returns to 0.
- A step occurs only on tick cycles. Prescale count holds while en=0, and clears on rst and on load.
- tc and cmp_match timing is unchanged relative to the step.
- Not defined: no prescale logic; every en=1 cycle without load is a step, and the PRESCALE parameter is ignored.

Test Plan:
1. Reset and load clamp: rst=1 for 2 cycles -> out=0, tc=0, cmp_match=0. With WIDTH=8, MAX_VAL=9, load data=200 -> out=9 next cycle.
2. Up wrap: MAX_VAL=9, sat_mode=0, up=1, en=1 from out=7 -> out 8, 9, 0, 1; tc=1 only in the cycle out=0.
3. Down saturate: sat_mode=0→1, up=0, en=1 from out=2 -> out 1, 0, 0, 0; tc=1 in each cycle after a step from 0 (2nd and 3rd zero cycles). Deassert en -> tc=0 and out holds 0.
4. Priority: rst=1, load=1, en=1 together -> out=0. Then load=1, en=1, data=5 -> out=5, no increment. Flip up each cycle with en=1 from 5 -> out 6, 5, 6.
5. Compare: cmp_val=3, count up from 0 with MAX_VAL=255 -> cmp_match=1 only in the cycle out=3. Hold en=0 at 3 -> cmp_match stays 1. Change cmp_val to 4 -> cmp_match=0 one cycle later.
6. Prescale (UDCNT_PRESCALE_EN, PRESCALE=4): en=1 for 8 cycles from 0 -> out reaches 1 after the 4th en-cycle and 2 after the 8th. en gap in the middle -> step is delayed by the gap length. Load mid-prescale -> next step requires 4 more en-cycles.
